// File: rtl/mem_wb_writeback.sv
// Memory-access / write-back stage: drives the register-file write port and a req/ack data-memory port.
// Optional REQ timeout abort is enabled by defining MEM_TIMEOUT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | accept upstream instruction; ALU ops write back next edge
// S_REQ  | memory request outstanding, upstream frozen until ack/abort
// S_RESP | completion cycle; upstream advances at this edge, inputs ignored
module mem_wb_writeback #(
   parameter int ADDR_BASE      = 1024,
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              WB_EN_IN,
   input  logic              MEM_R_EN_IN,
   input  logic              MEM_W_EN_IN,
   input  logic [31:0]       ALU_Res,
   input  logic [31:0]       Val_Rm,
   input  logic [3:0]        Dest_IN,
   output logic              freeze,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              writeBackEn,
   output logic [3:0]        Dest_wb,
   output logic [31:0]       Result_WB,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [3:0]        ld_dest_q, ld_dest_d;
   logic              wb_en_q, wb_en_d;
   logic [3:0]        dest_wb_q, dest_wb_d;
   logic [31:0]       result_q, result_d;
   logic              freeze_c;
   logic              mem_op;
   logic [31:0]       byte_off;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   assign mem_op   = MEM_R_EN_IN | MEM_W_EN_IN;
   // Subtraction wraps modulo 2^32 so addresses below the base alias high.
   assign byte_off = ALU_Res - 32'(ADDR_BASE);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      ld_dest_d = ld_dest_q;
      wb_en_d   = 1'b0;
      dest_wb_d = dest_wb_q;
      result_d  = result_q;
      freeze_c  = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               if (mem_op) begin
                  freeze_c  = 1'b1;
                  addr_d    = ADDR_W'(byte_off >> 2);
                  wdata_d   = Val_Rm;
                  we_d      = MEM_W_EN_IN;
                  ld_dest_d = Dest_IN;
                  state_d   = S_REQ;
`ifdef MEM_TIMEOUT_EN
                  cnt_d     = '0;
`endif
               end else begin
                  wb_en_d   = WB_EN_IN;
                  dest_wb_d = Dest_IN;
                  result_d  = ALU_Res;
               end
            end
         end
         S_REQ: begin
            freeze_c = 1'b1;
            if (mem_ack) begin
               if (!we_q) begin
                  wb_en_d   = 1'b1;
                  dest_wb_d = ld_dest_q;
                  result_d  = mem_rdata;
               end
               state_d = S_RESP;
            end
`ifdef MEM_TIMEOUT_EN
            // An ack in the expiry cycle takes the branch above instead.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         ld_dest_q <= '0;
         wb_en_q   <= 1'b0;
         dest_wb_q <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         ld_dest_q <= ld_dest_d;
         wb_en_q   <= wb_en_d;
         dest_wb_q <= dest_wb_d;
         result_q  <= result_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign mem_err = err_q;
`else
   assign mem_err = 1'b0;
`endif

   // Gated by rst so an IDLE mem op held through reset cannot stall upstream.
   assign freeze      = rst & freeze_c;
   assign mem_req     = (state_q == S_REQ);
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign writeBackEn = wb_en_q;
   assign Dest_wb     = dest_wb_q;
   assign Result_WB   = result_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: table of ALU-op vectors plus hand sequences for memory ops.
module tb_mem_wb_writeback;

   localparam int ADDR_W = 16;

   logic              clk;
   logic              rst;
   logic              valid;
   logic              WB_EN_IN;
   logic              MEM_R_EN_IN;
   logic              MEM_W_EN_IN;
   logic [31:0]       ALU_Res;
   logic [31:0]       Val_Rm;
   logic [3:0]        Dest_IN;
   logic              freeze;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;
   logic              writeBackEn;
   logic [3:0]        Dest_wb;
   logic [31:0]       Result_WB;
   logic              mem_err;

   int errors = 0;
   int checks = 0;

   mem_wb_writeback #(
      .ADDR_BASE(1024),
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .WB_EN_IN(WB_EN_IN),
      .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest_IN(Dest_IN),
      .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
      .Result_WB(Result_WB), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        wb;
      logic [31:0] alu;
      logic [3:0]  dest;
      logic        e_wb;
      logic [3:0]  e_dest;
      logic [31:0] e_res;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] vrm, input logic [3:0] dest);
      valid       = v;
      WB_EN_IN    = wb;
      MEM_R_EN_IN = rd;
      MEM_W_EN_IN = wr;
      ALU_Res     = alu;
      Val_Rm      = vrm;
      Dest_IN     = dest;
   endtask

   // Issues a load/store, acks in REQ cycle ack_n, and returns at the RESP cycle with inputs still held.
   task automatic mem_op(input string tag, input logic st, input logic [31:0] alu,
                         input logic [31:0] vrm, input logic [3:0] dest, input int ack_n,
                         input logic [31:0] rdata, input logic [15:0] e_addr,
                         input logic [31:0] e_res, input logic [3:0] e_dest);
      int frz;
      frz = 0;
      drive(1'b1, 1'b1, ~st, st, alu, vrm, dest);
      #1;
      if (freeze) frz++;
      chk({tag, "_req_idle"}, {31'd0, mem_req}, 32'd0);
      step();
      for (int n = 1; n <= ack_n; n++) begin
         chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
         if (n == 1) begin
            chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, e_addr});
            chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, st});
            if (st) chk({tag, "_wdata"}, mem_wdata, vrm);
         end
         if (n == ack_n) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         #1;
         if (freeze) frz++;
         step();
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
      chk({tag, "_frz_cycles"}, frz, ack_n + 1);
      chk({tag, "_resp_freeze"}, {31'd0, freeze}, 32'd0);
      chk({tag, "_resp_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_resp_wben"}, {31'd0, writeBackEn}, {31'd0, ~st});
      chk({tag, "_resp_res"}, Result_WB, e_res);
      chk({tag, "_resp_dest"}, {28'd0, Dest_wb}, {28'd0, e_dest});
      chk({tag, "_resp_err"}, {31'd0, mem_err}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 32'h0000_002A, 4'd3,  1'b1, 4'd3,  32'h0000_002A};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, 4'd5,  1'b0, 4'd5,  32'h0000_1234};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_FFFF, 4'd9,  1'b0, 4'd5,  32'h0000_1234};
      vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 4'd15, 1'b1, 4'd15, 32'hFFFF_FFFF};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 4'd0,  1'b1, 4'd0,  32'h0000_0000};

      rst       = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      repeat (3) step();
      chk("rst_wben", {31'd0, writeBackEn}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_freeze", {31'd0, freeze}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_res", Result_WB, 32'd0);
      chk("rst_dest", {28'd0, Dest_wb}, 32'd0);
      chk("rst_err", {31'd0, mem_err}, 32'd0);
      rst = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].wb, 1'b0, 1'b0, vecs[i].alu, 32'h0, vecs[i].dest);
         #1;
         chk($sformatf("vec%0d_freeze", i), {31'd0, freeze}, 32'd0);
         step();
         chk($sformatf("vec%0d_wben", i), {31'd0, writeBackEn}, {31'd0, vecs[i].e_wb});
         chk($sformatf("vec%0d_dest", i), {28'd0, Dest_wb}, {28'd0, vecs[i].e_dest});
         chk($sformatf("vec%0d_res", i), Result_WB, vecs[i].e_res);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();
      chk("idle_wben", {31'd0, writeBackEn}, 32'd0);

      mem_op("load", 1'b0, 32'd1032, 32'h0, 4'd7, 3, 32'hDEAD_BEEF, 16'd2, 32'hDEAD_BEEF, 4'd7);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();
      chk("load_after_wben", {31'd0, writeBackEn}, 32'd0);

      mem_op("store", 1'b1, 32'd1028, 32'd7, 4'd6, 1, 32'h0, 16'd1, 32'hDEAD_BEEF, 4'd7);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();
      chk("store_after_wben", {31'd0, writeBackEn}, 32'd0);

      // Both R and W set: store wins; ALU_Res below base wraps to the top of the word space.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd1020, 32'h1111_2222, 4'd2);
      step();
      chk("both_we", {31'd0, mem_we}, 32'd1);
      chk("wrap_addr", {16'd0, mem_addr}, 32'h0000_FFFF);
      chk("both_wdata", mem_wdata, 32'h1111_2222);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("both_wben", {31'd0, writeBackEn}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();

      // Spurious ack in IDLE, then back-to-back load and ALU op.
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      step();
      mem_ack   = 1'b0;
      chk("spur_req", {31'd0, mem_req}, 32'd0);
      chk("spur_wben", {31'd0, writeBackEn}, 32'd0);
      chk("spur_freeze", {31'd0, freeze}, 32'd0);
      mem_op("b2b_load", 1'b0, 32'd1040, 32'h0, 4'd9, 2, 32'h0000_0ABC, 16'd4, 32'h0000_0ABC, 4'd9);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd2);
      step();
      chk("b2b_idle_wben", {31'd0, writeBackEn}, 32'd0);
      chk("b2b_idle_freeze", {31'd0, freeze}, 32'd0);
      step();
      chk("b2b_alu_wben", {31'd0, writeBackEn}, 32'd1);
      chk("b2b_alu_res", Result_WB, 32'h0000_0055);
      chk("b2b_alu_dest", {28'd0, Dest_wb}, 32'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();
      chk("b2b_end_wben", {31'd0, writeBackEn}, 32'd0);

      // Reset in the middle of a REQ.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd8);
      step();
      chk("mid_req_before", {31'd0, mem_req}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_freeze", {31'd0, freeze}, 32'd0);
      chk("mid_rst_wben", {31'd0, writeBackEn}, 32'd0);
      chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 4'd4);
      #1;
      chk("post_rst_freeze", {31'd0, freeze}, 32'd0);
      chk("post_rst_req", {31'd0, mem_req}, 32'd0);
      step();
      chk("post_rst_wben", {31'd0, writeBackEn}, 32'd1);
      chk("post_rst_res", Result_WB, 32'h0000_0099);
      chk("post_rst_dest", {28'd0, Dest_wb}, 32'd4);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();

`ifdef MEM_TIMEOUT_EN
      begin
         int reqc;
         int errc;
         reqc = 0;
         errc = 0;
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1);
         step();
         for (int i = 0; i < 20 && mem_req; i++) begin
            reqc++;
            if (mem_err) errc++;
            step();
         end
         chk("to_req_cycles", reqc, 4);
         chk("to_err_early", errc, 0);
         chk("to_err", {31'd0, mem_err}, 32'd1);
         chk("to_wben", {31'd0, writeBackEn}, 32'd0);
         chk("to_freeze", {31'd0, freeze}, 32'd0);
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
         step();
         chk("to_err_pulse", {31'd0, mem_err}, 32'd0);
         mem_op("to_ack_wins", 1'b0, 32'd1036, 32'h0, 4'd12, 4, 32'h0BAD_F00D, 16'd3, 32'h0BAD_F00D, 4'd12);
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
         step();
      end
`else
      mem_op("long_load", 1'b0, 32'd1036, 32'h0, 4'd12, 8, 32'h0BAD_F00D, 16'd3, 32'h0BAD_F00D, 4'd12);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
